// File: rtl/bcd_display_driver_if.sv
// Bus between a controller and bcd_display_driver: the load request with its
// value/radix, and the status flags plus the active-low seven-segment field.
interface bcd_display_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    Value;
  logic                Load;
  logic                Mode;
  logic                Busy;
  logic                Done;
  logic                Overflow;
  logic [7*DIGITS-1:0] HEX;

  // Controller side: requests conversions and watches the display.
  modport master (
    output Value, Load, Mode,
    input  Busy, Done, Overflow, HEX
  );

  // Driver side.
  modport slave (
    input  Value, Load, Mode,
    output Busy, Done, Overflow, HEX
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Binary-to-seven-segment display driver. A load in IDLE latches a binary
// value and a radix. Decimal values go through a double-dabble converter, one
// shift-add-3 step per clock for WIDTH clocks; hex values skip straight to the
// display update. The display register only changes in the SHOW state, so the
// partially converted BCD never reaches the segments.
module bcd_display_driver #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  bcd_display_driver_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time constants
  // ---------------------------------------------------------------------------

  // Decimal digits needed for the largest input, 2^w - 1.
  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  // 10^n, the smallest value that no longer fits in n decimal digits.
  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  localparam int DEC_NIB = dec_digits(WIDTH);
  // The BCD register always covers the displayed digits, and grows by extra
  // nibbles when the input range needs more decimal digits than are shown,
  // so overflowing values never corrupt the low digits during conversion.
  localparam int NIB     = (DEC_NIB > DIGITS) ? DEC_NIB : DIGITS;
  localparam int BCD_W   = 4 * NIB;
  localparam int SR_W    = BCD_W + WIDTH;
  localparam int HEX_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(WIDTH);

  localparam logic [31:0]      DEC_LIMIT = 32'(pow10(DIGITS));
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] SHOW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Active-low glyphs, bit 6 = segment a down to bit 0 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  logic [1:0]          state_q;
  logic [WIDTH-1:0]    value_q;
  logic                mode_q;
  logic [SR_W-1:0]     sr_q;     // {bcd nibbles, binary remainder}
  logic [CNT_W-1:0]    step_q;
  logic [7*DIGITS-1:0] hex_q;
  logic                ovf_q;

  logic [SR_W-1:0]     sr_step;
  logic [HEX_W-1:0]    value_hex;
  logic                hex_ovf;
  logic                dec_ovf;
  logic                ovf_new;
  logic [7*DIGITS-1:0] hex_new;
  logic [3:0]          digit [DIGITS];

  // ---------------------------------------------------------------------------
  // Double-dabble step
  // ---------------------------------------------------------------------------

  // One conversion step: add 3 to every BCD nibble >= 5, then shift left.
  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (here by copying sr_q first); a path that skips an assignment infers a latch.
  always_comb begin
    logic [SR_W-1:0] adj;
    adj = sr_q;
    for (int k = 0; k < NIB; k++) begin
      if (adj[WIDTH + 4*k +: 4] >= 4'd5) begin
        adj[WIDTH + 4*k +: 4] = adj[WIDTH + 4*k +: 4] + 4'd3;
      end
    end
    sr_step = {adj[SR_W-2:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Hex view of the latched value and its overflow test
  // ---------------------------------------------------------------------------

  generate
    if (WIDTH > HEX_W) begin : g_hex_wide
      assign value_hex = value_q[HEX_W-1:0];
      assign hex_ovf   = |value_q[WIDTH-1:HEX_W];
    end else if (WIDTH == HEX_W) begin : g_hex_exact
      assign value_hex = value_q;
      assign hex_ovf   = 1'b0;
    end else begin : g_hex_narrow
      assign value_hex = {{(HEX_W - WIDTH){1'b0}}, value_q};
      assign hex_ovf   = 1'b0;
    end
  endgenerate

  assign dec_ovf = ({{(32 - WIDTH){1'b0}}, value_q} >= DEC_LIMIT);
  assign ovf_new = mode_q ? hex_ovf : dec_ovf;

  // ---------------------------------------------------------------------------
  // Segment image for the finished conversion
  // ---------------------------------------------------------------------------

  // Pick the digit nibbles, then apply overflow dashes and leading-zero
  // blanking working down from the most significant digit.
  always_comb begin
    logic upper_zero;
    logic [6:0] seg;
    hex_new    = '0;
    upper_zero = 1'b1;
    seg        = SEG_BLANK;
    for (int k = 0; k < DIGITS; k++) begin
      digit[k] = mode_q ? value_hex[4*k +: 4] : sr_q[WIDTH + 4*k +: 4];
    end
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (digit[k] == 4'd0);
      if (ovf_new) begin
        seg = SEG_DASH;
      end else if ((k != 0) && upper_zero) begin
        seg = SEG_BLANK;
      end else begin
        seg = glyph(digit[k]);
      end
      hex_new[7*k +: 7] = seg;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registers
  // ---------------------------------------------------------------------------

  // Load acceptance, conversion stepping and display capture.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= IDLE;
      value_q <= '0;
      mode_q  <= 1'b0;
      sr_q    <= '0;
      step_q  <= '0;
      hex_q   <= {DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Load) begin
            value_q <= bus.Value;
            mode_q  <= bus.Mode;
            sr_q    <= {{BCD_W{1'b0}}, bus.Value};
            step_q  <= '0;
            state_q <= bus.Mode ? SHOW : CONVERT;
          end
        end
        CONVERT: begin
          sr_q   <= sr_step;
          step_q <= step_q + CNT_W'(1);
          if (step_q == LAST_STEP) begin
            state_q <= SHOW;
          end
        end
        SHOW: begin
          hex_q   <= hex_new;
          ovf_q   <= ovf_new;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // During SHOW the fresh image is passed through so it appears together with
  // Done; afterwards the captured copy holds it until the next SHOW.
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == SHOW);
  assign bus.HEX      = (state_q == SHOW) ? hex_new : hex_q;
  assign bus.Overflow = (state_q == SHOW) ? ovf_new : ovf_q;

endmodule
